ucie_ctl_sb_packet_assembler: RTL



---
 rtl/ucie_ctl_sb_pkg.sv | 37 +++
 rtl/ucie_ctl_sb_packet_assembler_parity_chk.sv | 16 +
 rtl/ucie_ctl_sb_packet_assembler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Sideband packet assembler shared definitions:
// opcodes, parity bit positions, FSM encoding and payload classifier.
package ucie_ctl_sb_pkg;

    localparam int SB_OPC_W  = 5;
    localparam int SB_WORD_W = 32;

    localparam logic [4:0] MEM_WR32 = 5'b00001;
    localparam logic [4:0] CFG_WR32 = 5'b00101;
    localparam logic [4:0] MEM_WR64 = 5'b01001;
    localparam logic [4:0] CFG_WR64 = 5'b01101;
    localparam logic [4:0] CPL_D32  = 5'b10001;
    localparam logic [4:0] CPL_D64  = 5'b11001;
    localparam logic [4:0] MSG_D64  = 5'b11011;
    localparam logic [4:0] MSG_ND   = 5'b10010;

    localparam int CP_BIT = 62;
    localparam int DP_BIT = 63;

    typedef enum logic [1:0] {
        ST_HDR0 = 2'd0,
        ST_HDR1 = 2'd1,
        ST_DAT0 = 2'd2,
        ST_DAT1 = 2'd3
    } sb_state_e;

    function automatic logic has_data(input logic [4:0] opc);
        logic r;
        case (opc)
            MEM_WR32, CFG_WR32, MEM_WR64, CFG_WR64,
            CPL_D32, CPL_D64, MSG_D64: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_packet_assembler_parity_chk.sv
// Combinational control/data parity check for one completed packet.
// CP covers hdr[61:0]; DP covers the whole payload and is masked without one.
module ucie_ctl_sb_parity_chk
    import ucie_ctl_sb_pkg::*;
(
    input  logic [63:0] hdr_i,
    input  logic [63:0] data_i,
    input  logic        has_data_i,
    output logic        cp_err_o,
    output logic        dp_err_o
);

    assign cp_err_o = (^hdr_i[CP_BIT-1:0]) != hdr_i[CP_BIT];
    assign dp_err_o = has_data_i & ((^data_i) != hdr_i[DP_BIT]);

endmodule

// File: rtl/ucie_ctl_sb_packet_assembler.sv
// Frames 32-bit sideband words into header/payload packets and holds
// one finished packet at a valid/ready output while the next assembles.
module ucie_ctl_sb_packet_assembler
    import ucie_ctl_sb_pkg::*;
#(
    parameter int OPC_W  = SB_OPC_W,
    parameter int WORD_W = SB_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_abort,
    input  logic              i_pkt_ready,
    output logic              o_pkt_valid,
    output logic [63:0]       o_hdr,
    output logic [63:0]       o_data,
    output logic              o_has_data,
    output logic              o_cp_err,
    output logic              o_dp_err,
    output logic              o_overflow
);

    sb_state_e   state_q, state_d;
    logic [63:0] asm_hdr_q;
    logic [31:0] asm_dat_q;

    logic        lat_hdr0, lat_hdr1, lat_dat0;
    logic        complete, cmp_has_data;
    logic        strobe, load;
    logic [63:0] cmp_hdr, cmp_data;
    logic        cmp_cp_err, cmp_dp_err;

    logic        valid_q, has_data_q, cp_err_q, dp_err_q, ovf_q;
    logic [63:0] hdr_q, data_q;

    assign strobe = i_word_valid & ~i_abort;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_HDR0;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_HDR0;
        end else if (i_word_valid) begin
            unique case (state_q)
                ST_HDR0: state_d = ST_HDR1;
                ST_HDR1: state_d = has_data(asm_hdr_q[OPC_W-1:0]) ? ST_DAT0 : ST_HDR0;
                ST_DAT0: state_d = ST_DAT1;
                ST_DAT1: state_d = ST_HDR0;
            endcase
        end
    end

    always_comb begin
        lat_hdr0     = 1'b0;
        lat_hdr1     = 1'b0;
        lat_dat0     = 1'b0;
        complete     = 1'b0;
        cmp_has_data = 1'b0;
        if (strobe) begin
            unique case (state_q)
                ST_HDR0: lat_hdr0 = 1'b1;
                ST_HDR1: begin
                    lat_hdr1 = 1'b1;
                    complete = ~has_data(asm_hdr_q[OPC_W-1:0]);
                end
                ST_DAT0: lat_dat0 = 1'b1;
                ST_DAT1: begin
                    complete     = 1'b1;
                    cmp_has_data = 1'b1;
                end
            endcase
        end
    end

    // A no-data packet completes on its upper header word, taken straight from the input.
    assign cmp_hdr  = (state_q == ST_DAT1) ? asm_hdr_q
                                           : {i_word, asm_hdr_q[31:0]};
    assign cmp_data = cmp_has_data ? {i_word, asm_dat_q} : 64'd0;

    ucie_ctl_sb_parity_chk u_parity (
        .hdr_i      (cmp_hdr),
        .data_i     (cmp_data),
        .has_data_i (cmp_has_data),
        .cp_err_o   (cmp_cp_err),
        .dp_err_o   (cmp_dp_err)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            asm_hdr_q <= '0;
            asm_dat_q <= '0;
        end else begin
            if (lat_hdr0) asm_hdr_q[31:0]  <= i_word;
            if (lat_hdr1) asm_hdr_q[63:32] <= i_word;
            if (lat_dat0) asm_dat_q        <= i_word;
        end
    end

    assign load = complete & (~valid_q | i_pkt_ready);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            hdr_q      <= '0;
            data_q     <= '0;
            has_data_q <= 1'b0;
            cp_err_q   <= 1'b0;
            dp_err_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= complete & valid_q & ~i_pkt_ready;
            if (load) begin
                valid_q    <= 1'b1;
                hdr_q      <= cmp_hdr;
                data_q     <= cmp_data;
                has_data_q <= cmp_has_data;
                cp_err_q   <= cmp_cp_err;
                dp_err_q   <= cmp_dp_err;
            end else if (i_pkt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_pkt_valid = valid_q;
    assign o_hdr       = hdr_q;
    assign o_data      = data_q;
    assign o_has_data  = has_data_q;
    assign o_cp_err    = cp_err_q;
    assign o_dp_err    = dp_err_q;
    assign o_overflow  = ovf_q;

endmodule
